// File: rtl/hist_percentile_reader_pkg.sv
// Shared types and constants for the histogram percentile reader.
// The FSM uses one-hot state encoding.
package hist_percentile_reader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  // Guard bit on each saturating add; a carry out of it means clamp to all-ones.
  localparam int SAT_CARRY_BITS = 1;

endpackage

// File: rtl/hist_sweep_addr_gen.sv
// Sweep address counter for the histogram read port.
// Delays a valid flag and bin index by one cycle so they line up with read data.
module hist_sweep_addr_gen #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 en_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_o,
  output logic                 vld_o,
  output logic [ADDR_BITS-1:0] idx_o
);

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 vld_q;
  logic [ADDR_BITS-1:0] idx_q;

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (en_i) begin
      addr_d = addr_q + ADDR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      addr_q <= addr_d;
      vld_q  <= en_i;
      idx_q  <= addr_q;
    end
  end

  assign addr_o = addr_q;
  assign last_o = &addr_q;
  assign vld_o  = vld_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/hist_percentile_reader.sv
// Sweeps the frozen histogram once per start pulse. It reports the total count, the
// bin-weighted sum, and the first bins whose cumulative count reaches lo_thr/hi_thr.
module hist_percentile_reader
  import hist_percentile_reader_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 24,
  parameter int SUM_BITS  = 32,
  parameter int WSUM_BITS = SUM_BITS + ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SUM_BITS-1:0]  lo_thr,
  input  logic [SUM_BITS-1:0]  hi_thr,
  output logic                 hist_en,
  output logic [ADDR_BITS-1:0] hist_addr,
  input  logic [DATA_BITS-1:0] hist_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] lo_bin,
  output logic [ADDR_BITS-1:0] hi_bin,
  output logic [SUM_BITS-1:0]  hist_sum,
  output logic [WSUM_BITS-1:0] hist_wsum
);

  localparam int PROD_BITS = ADDR_BITS + DATA_BITS;

  state_e               state_q, state_d;
  logic [SUM_BITS-1:0]  lo_thr_q, lo_thr_d, hi_thr_q, hi_thr_d;
  logic [SUM_BITS-1:0]  cum_q, cum_d;
  logic [WSUM_BITS-1:0] wsum_q, wsum_d;
  logic                 lo_found_q, lo_found_d, hi_found_q, hi_found_d;
  logic [ADDR_BITS-1:0] lo_idx_q, lo_idx_d, hi_idx_q, hi_idx_d;
  logic [ADDR_BITS-1:0] lo_bin_q, lo_bin_d, hi_bin_q, hi_bin_d;
  logic [SUM_BITS-1:0]  sum_res_q, sum_res_d;
  logic [WSUM_BITS-1:0] wsum_res_q, wsum_res_d;

  logic                 sweep_clear;
  logic                 addr_last;
  logic                 pipe_vld;
  logic [ADDR_BITS-1:0] pipe_idx;

  logic [SUM_BITS-1:0]                 data_ext;
  logic [SUM_BITS+SAT_CARRY_BITS-1:0]  cum_wide;
  logic [SUM_BITS-1:0]                 cum_sat;
  logic [PROD_BITS-1:0]                prod;
  logic [WSUM_BITS+SAT_CARRY_BITS-1:0] wsum_wide;
  logic [WSUM_BITS-1:0]                wsum_sat;

  assign hist_en     = (state_q == ST_READ);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign sweep_clear = (state_q == ST_IDLE) && start;

  hist_sweep_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (sweep_clear),
    .en_i    (hist_en),
    .addr_o  (hist_addr),
    .last_o  (addr_last),
    .vld_o   (pipe_vld),
    .idx_o   (pipe_idx)
  );

  // Saturating accumulate of the bin count and its index-weighted product.
  assign data_ext  = SUM_BITS'(hist_data);
  assign cum_wide  = {1'b0, cum_q} + {1'b0, data_ext};
  assign cum_sat   = cum_wide[SUM_BITS] ? '1 : cum_wide[SUM_BITS-1:0];
  assign prod      = PROD_BITS'(pipe_idx) * PROD_BITS'(hist_data);
  assign wsum_wide = {1'b0, wsum_q} + (WSUM_BITS+SAT_CARRY_BITS)'(prod);
  assign wsum_sat  = wsum_wide[WSUM_BITS] ? '1 : wsum_wide[WSUM_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    lo_thr_d   = lo_thr_q;
    hi_thr_d   = hi_thr_q;
    cum_d      = cum_q;
    wsum_d     = wsum_q;
    lo_found_d = lo_found_q;
    hi_found_d = hi_found_q;
    lo_idx_d   = lo_idx_q;
    hi_idx_d   = hi_idx_q;
    lo_bin_d   = lo_bin_q;
    hi_bin_d   = hi_bin_q;
    sum_res_d  = sum_res_q;
    wsum_res_d = wsum_res_q;

    if (pipe_vld) begin
      cum_d  = cum_sat;
      wsum_d = wsum_sat;
      if (!lo_found_q && (cum_sat >= lo_thr_q)) begin
        lo_found_d = 1'b1;
        lo_idx_d   = pipe_idx;
      end
      if (!hi_found_q && (cum_sat >= hi_thr_q)) begin
        hi_found_d = 1'b1;
        hi_idx_d   = pipe_idx;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_READ;
          lo_thr_d   = lo_thr;
          hi_thr_d   = hi_thr;
          cum_d      = '0;
          wsum_d     = '0;
          lo_found_d = 1'b0;
          hi_found_d = 1'b0;
          lo_idx_d   = '0;
          hi_idx_d   = '0;
        end
      end
      ST_READ: begin
        if (addr_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Results take the values that include the last bin, so they become
        // visible together with done.
        state_d    = ST_DONE;
        lo_bin_d   = lo_found_d ? lo_idx_d : '1;
        hi_bin_d   = hi_found_d ? hi_idx_d : '1;
        sum_res_d  = cum_d;
        wsum_res_d = wsum_d;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lo_thr_q   <= '0;
      hi_thr_q   <= '0;
      cum_q      <= '0;
      wsum_q     <= '0;
      lo_found_q <= 1'b0;
      hi_found_q <= 1'b0;
      lo_idx_q   <= '0;
      hi_idx_q   <= '0;
      lo_bin_q   <= '0;
      hi_bin_q   <= '0;
      sum_res_q  <= '0;
      wsum_res_q <= '0;
    end else begin
      state_q    <= state_d;
      lo_thr_q   <= lo_thr_d;
      hi_thr_q   <= hi_thr_d;
      cum_q      <= cum_d;
      wsum_q     <= wsum_d;
      lo_found_q <= lo_found_d;
      hi_found_q <= hi_found_d;
      lo_idx_q   <= lo_idx_d;
      hi_idx_q   <= hi_idx_d;
      lo_bin_q   <= lo_bin_d;
      hi_bin_q   <= hi_bin_d;
      sum_res_q  <= sum_res_d;
      wsum_res_q <= wsum_res_d;
    end
  end

  assign lo_bin    = lo_bin_q;
  assign hi_bin    = hi_bin_q;
  assign hist_sum  = sum_res_q;
  assign hist_wsum = wsum_res_q;

endmodule

// File: tb/tb_hist_percentile_reader.sv
// Directed and randomized bench for hist_percentile_reader with a RAM model and a
// loop-based percentile reference model.
module tb_hist_percentile_reader;

  logic        clk;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] lo_thr, hi_thr;
  logic [23:0] lo_thr2, hi_thr2;
  logic        hist_en, hist_en2;
  logic [7:0]  hist_addr, hist_addr2;
  logic [23:0] hist_data, hist_data2;
  logic        busy, busy2, done, done2;
  logic [7:0]  lo_bin, hi_bin, lo_bin2, hi_bin2;
  logic [31:0] hist_sum;
  logic [39:0] hist_wsum;
  logic [23:0] hist_sum2;
  logic [31:0] hist_wsum2;

  logic [23:0] mem [256];
  int checks   = 0;
  int failures = 0;

  hist_percentile_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lo_thr(lo_thr), .hi_thr(hi_thr),
    .hist_en(hist_en), .hist_addr(hist_addr), .hist_data(hist_data),
    .busy(busy), .done(done), .lo_bin(lo_bin), .hi_bin(hi_bin),
    .hist_sum(hist_sum), .hist_wsum(hist_wsum)
  );

  hist_percentile_reader #(.SUM_BITS(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .start(start2), .lo_thr(lo_thr2), .hi_thr(hi_thr2),
    .hist_en(hist_en2), .hist_addr(hist_addr2), .hist_data(hist_data2),
    .busy(busy2), .done(done2), .lo_bin(lo_bin2), .hi_bin(hi_bin2),
    .hist_sum(hist_sum2), .hist_wsum(hist_wsum2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Histogram RAM: one-cycle read latency, random garbage when not enabled.
  always @(posedge clk) begin
    hist_data  <= hist_en  ? mem[hist_addr]  : 24'($urandom);
    hist_data2 <= hist_en2 ? mem[hist_addr2] : 24'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the bins, clamp running totals to the given widths.
  function automatic void model(input int sb, input int wb, input logic [63:0] lo,
                                input logic [63:0] hi, output logic [63:0] e_lo,
                                output logic [63:0] e_hi, output logic [63:0] e_sum,
                                output logic [63:0] e_wsum);
    longint unsigned smax, wmax, cum, ws;
    bit lf, hf;
    smax = (64'd1 << sb) - 1;
    wmax = (64'd1 << wb) - 1;
    cum = 0; ws = 0; lf = 0; hf = 0;
    e_lo = 255; e_hi = 255;
    for (int i = 0; i < 256; i++) begin
      cum = cum + mem[i];
      if (cum > smax) cum = smax;
      ws = ws + longint'(i) * mem[i];
      if (ws > wmax) ws = wmax;
      if (!lf && cum >= lo) begin lf = 1; e_lo = i; end
      if (!hf && cum >= hi) begin hf = 1; e_hi = i; end
    end
    e_sum = cum;
    e_wsum = ws;
  endfunction

  task automatic check_results(input logic [63:0] lo, input logic [63:0] hi);
    logic [63:0] e_lo, e_hi, e_sum, e_wsum;
    model(32, 40, lo, hi, e_lo, e_hi, e_sum, e_wsum);
    check("lo_bin", lo_bin, e_lo);
    check("hi_bin", hi_bin, e_hi);
    check("hist_sum", hist_sum, e_sum);
    check("hist_wsum", hist_wsum, e_wsum);
  endtask

  // One sweep with per-cycle checks of hist_en/hist_addr, busy and done timing.
  task automatic run_sweep(input logic [31:0] lo, input logic [31:0] hi,
                           input bit disturb);
    int en_bad = 0, busy_bad = 0, done_cnt = 0, done_cyc = 0;
    bit exp_en;
    @(posedge clk); #1;
    lo_thr = lo; hi_thr = hi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 265; c++) begin
      @(negedge clk);
      exp_en = (c <= 256);
      if (hist_en !== exp_en || (exp_en && hist_addr !== 8'(c - 1))) en_bad++;
      if (busy !== (c <= 258)) busy_bad++;
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (disturb) begin
        if (c == 20) begin lo_thr = $urandom; hi_thr = $urandom; end
        if (c == 50 || c == 258) start = 1'b1;
        if (c == 51 || c == 259) start = 1'b0;
      end
    end
    check("en_addr_bad_cycles", en_bad, 0);
    check("busy_bad_cycles", busy_bad, 0);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, 258);
    check_results(lo, hi);
  endtask

  initial begin
    logic [63:0] e_lo, e_hi, e_sum, e_wsum;
    logic [31:0] total, maxv, lo_r, hi_r;
    bit found;
    int done_cnt, done_cyc;

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    lo_thr = '0; hi_thr = '0; lo_thr2 = '0; hi_thr2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hist_en", hist_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", hist_addr, 0);
    check("rst_results", {lo_bin, hi_bin, hist_sum, hist_wsum}, 0);
    check("rst_dut24", {hist_en2, busy2, done2, lo_bin2, hi_bin2, hist_sum2, hist_wsum2}, 0);
    rst_n = 1'b1;

    // Scenario 1: empty histogram
    run_sweep(32'd0, 32'd1, 1'b0);
    check("s1_lo_bin_const", lo_bin, 0);
    check("s1_hi_bin_const", hi_bin, 255);

    // Scenario 2: single spike
    mem[100] = 24'd1000;
    run_sweep(32'd10, 32'd990, 1'b0);
    check("s2_wsum_const", hist_wsum, 100000);

    // Scenario 3: flat histogram
    for (int i = 0; i < 256; i++) mem[i] = 24'd4;
    run_sweep(32'd8, 32'd1024, 1'b0);
    check("s3_lo_bin_const", lo_bin, 1);
    check("s3_wsum_const", hist_wsum, 130560);

    // Randomized histograms, the first with mid-sweep disturbances
    for (int t = 0; t < 4; t++) begin
      case (t % 3)
        0: maxv = 32'd15;
        1: maxv = 32'd4095;
        default: maxv = 32'hFFFFFF;
      endcase
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(0, maxv));
      model(32, 40, 64'd0, 64'd0, e_lo, e_hi, e_sum, e_wsum);
      total = e_sum[31:0];
      lo_r = $urandom_range(0, total);
      hi_r = (t == 2 && total != 32'hFFFFFFFF) ? total + 1 : $urandom_range(lo_r, total);
      run_sweep(lo_r, hi_r, t == 0);
    end

    // Scenario 5: reset mid-sweep, then rerun scenario 2
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[100] = 24'd1000;
    @(posedge clk); #1;
    lo_thr = 32'd10; hi_thr = 32'd990; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (hist_en === 1'b1 && hist_addr === 8'd100) found = 1;
    end
    check("rst_wait_addr100", found, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_en_busy_done", {hist_en, busy, done}, 0);
    check("midrst_addr", hist_addr, 0);
    check("midrst_results", {lo_bin, hi_bin, hist_sum, hist_wsum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || hist_en === 1'b1) done_cnt++;
    end
    check("midrst_no_activity", done_cnt, 0);
    run_sweep(32'd10, 32'd990, 1'b0);

    // Scenario 6: 24-bit sums saturate on a full histogram
    for (int i = 0; i < 256; i++) mem[i] = 24'hFFFFFF;
    @(posedge clk); #1;
    lo_thr2 = 24'd1; hi_thr2 = 24'hFFFFFF; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin done_cnt++; done_cyc = c; end
    end
    check("s6_done_count", done_cnt, 1);
    check("s6_done_cycle", done_cyc, 258);
    model(24, 32, 64'd1, 64'hFFFFFF, e_lo, e_hi, e_sum, e_wsum);
    check("s6_lo_bin", lo_bin2, e_lo);
    check("s6_hi_bin", hi_bin2, e_hi);
    check("s6_hist_sum", hist_sum2, e_sum);
    check("s6_hist_wsum", hist_wsum2, e_wsum);
    check("s6_sum_sat_const", hist_sum2, 24'hFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
